// File: rtl/hazard_controller.sv
// Hazard controller for the 5-stage RV32I pipeline.
// Combinational forwarding selects, load-use and branch hazard resolution,
// and a data-memory wait handshake with a sticky timeout flag.
// Saturating performance counters track stall cycles and branch flushes.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_RUN      | normal flow, no outstanding memory wait
// ST_MEM_WAIT | Memory stage is waiting on data memory, wait_cnt advancing

module hazard_controller #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic             UseRs1D,
  input  logic             UseRs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic             RegWriteE,
  input  logic [1:0]       ResultSrcE,
  input  logic             PCSrcE,
  input  logic [4:0]       RdM,
  input  logic             RegWriteM,
  input  logic [4:0]       RdW,
  input  logic             RegWriteW,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int WC_W = $clog2(MEM_TIMEOUT) + 1;
  // The flag rises on the edge where wait_cnt steps to MEM_TIMEOUT-1,
  // i.e. at the end of the MEM_TIMEOUT-th consecutive wait cycle.
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(MEM_TIMEOUT - 1);
  localparam logic [WC_W-1:0] WC_ARM  = WC_W'(MEM_TIMEOUT - 2);
  localparam logic [WC_W-1:0] WC_ONE  = WC_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [WC_W-1:0]   r_wait_cnt;
  logic              r_mem_timeout;
  logic [CNT_W-1:0]  r_stall_count;
  logic [CNT_W-1:0]  r_flush_count;

  logic              w_memwait;
  logic              w_lwstall;
  logic              w_branch_flush;

  // Hazard detection terms; x0 is never a real dependency.
  always_comb begin
    w_memwait = MemReqM & ~MemReadyM;
    w_lwstall = (ResultSrcE == 2'b01) & RegWriteE & (RdE != 5'd0) &
                ((UseRs1D & (Rs1D == RdE)) | (UseRs2D & (Rs2D == RdE)));
    w_branch_flush = ~rst & ~w_memwait & PCSrcE;
  end

  // Forwarding selects, Memory stage takes priority over Writeback.
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (!rst) begin
      if (RegWriteM && (RdM != 5'd0) && (RdM == Rs1E))
        ForwardAE = 2'b10;
      else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs1E))
        ForwardAE = 2'b01;
      if (RegWriteM && (RdM != 5'd0) && (RdM == Rs2E))
        ForwardBE = 2'b10;
      else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs2E))
        ForwardBE = 2'b01;
    end
  end

  // Stall/flush priority: reset, memory wait, taken branch, load-use.
  // A branch or load-use held behind a memory wait acts as soon as the
  // wait drops, because the stalled E/D registers still present it.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (rst) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
      FlushW = 1'b1;
    end else if (w_memwait) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else if (PCSrcE) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (w_lwstall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
  end

  // Next-state for the memory wait tracker.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_RUN:      if (w_memwait)  w_state_next = ST_MEM_WAIT;
      ST_MEM_WAIT: if (!w_memwait) w_state_next = ST_RUN;
      default:     w_state_next = ST_RUN;
    endcase
  end

  // State register, wait counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_RUN;
      r_wait_cnt    <= '0;
      r_mem_timeout <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (r_state == ST_RUN) begin
        if (w_memwait) r_wait_cnt <= '0;
      end else if (w_memwait) begin
        if (r_wait_cnt < WC_LAST) r_wait_cnt <= r_wait_cnt + WC_ONE;
        if (r_wait_cnt >= WC_ARM) r_mem_timeout <= 1'b1;
      end
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_count <= '0;
      r_flush_count <= '0;
    end else begin
      if (StallF && (r_stall_count != CNT_MAX))
        r_stall_count <= r_stall_count + CNT_ONE;
      if (w_branch_flush && (r_flush_count != CNT_MAX))
        r_flush_count <= r_flush_count + CNT_ONE;
    end
  end

  assign mem_timeout = r_mem_timeout;
  assign stall_count = r_stall_count;
  assign flush_count = r_flush_count;

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: directed scenarios followed by
// randomized traffic, all checked against a behavioural reference model.

module tb_hazard_controller;

  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 4;
  localparam int CNT_SAT     = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic UseRs1D, UseRs2D, RegWriteE, PCSrcE, RegWriteM, RegWriteW;
  logic MemReqM, MemReadyM;
  logic [1:0] ResultSrcE;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
  logic [1:0] ForwardAE, ForwardBE;
  logic mem_timeout;
  logic [CNT_W-1:0] stall_count, flush_count;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  int  m_stall_cnt;
  int  m_flush_cnt;
  int  m_consec_wait;
  bit  m_timeout;

  always #5 clk = ~clk;

  hazard_controller #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .UseRs1D(UseRs1D), .UseRs2D(UseRs2D),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RegWriteE(RegWriteE),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
    .RdM(RdM), .RegWriteM(RegWriteM), .RdW(RdW), .RegWriteW(RegWriteW),
    .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .mem_timeout(mem_timeout), .stall_count(stall_count), .flush_count(flush_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
    if (rst) return 2'b00;
    if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
    if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  // Returns {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW}.
  function automatic logic [6:0] ref_ctl();
    bit memwait, lw;
    memwait = MemReqM && !MemReadyM;
    lw = ResultSrcE == 2'b01 && RegWriteE && RdE != 0 &&
         ((UseRs1D && Rs1D == RdE) || (UseRs2D && Rs2D == RdE));
    if (rst)          return 7'b0000_111;
    if (memwait)      return 7'b1111_001;
    if (PCSrcE)       return 7'b0000_110;
    if (lw)           return 7'b1100_010;
    return 7'b0000_000;
  endfunction

  task automatic clear_inputs();
    rst = 0;
    Rs1D = 0; Rs2D = 0; UseRs1D = 0; UseRs2D = 0;
    Rs1E = 0; Rs2E = 0; RdE = 0; RegWriteE = 0; ResultSrcE = 0; PCSrcE = 0;
    RdM = 0; RegWriteM = 0; RdW = 0; RegWriteW = 0;
    MemReqM = 0; MemReadyM = 0;
  endtask

  // Check outputs mid-cycle, advance the model, move to just after the next edge.
  task automatic cycle(input string tag);
    logic [6:0] ctl;
    @(negedge clk);
    ctl = ref_ctl();
    check({tag, "_ctl"}, {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}, ctl);
    check({tag, "_fwdA"}, ForwardAE, ref_fwd(Rs1E));
    check({tag, "_fwdB"}, ForwardBE, ref_fwd(Rs2E));
    check({tag, "_stall_count"}, stall_count, m_stall_cnt);
    check({tag, "_flush_count"}, flush_count, m_flush_cnt);
    check({tag, "_mem_timeout"}, mem_timeout, m_timeout);
    if (rst) begin
      m_stall_cnt = 0; m_flush_cnt = 0; m_consec_wait = 0; m_timeout = 0;
    end else begin
      if (ctl[6] && m_stall_cnt < CNT_SAT) m_stall_cnt++;
      if (PCSrcE && !(MemReqM && !MemReadyM) && m_flush_cnt < CNT_SAT) m_flush_cnt++;
      if (MemReqM && !MemReadyM) begin
        m_consec_wait++;
        if (m_consec_wait >= MEM_TIMEOUT) m_timeout = 1;
      end else begin
        m_consec_wait = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    cycle("rst");
    cycle("rst");
    rst = 0;
  endtask

  int wait_left;

  initial begin
    m_stall_cnt = 0; m_flush_cnt = 0; m_consec_wait = 0; m_timeout = 0;
    clear_inputs();
    rst = 1;
    @(posedge clk); #1;
    cycle("rst0");
    rst = 0;

    // 1: load-use on x5
    RdE = 5; ResultSrcE = 2'b01; RegWriteE = 1; UseRs1D = 1; Rs1D = 5;
    cycle("t1_lw");
    clear_inputs();
    cycle("t1_after");
    check("t1_stall_count_is_1", stall_count, 1);

    // 2: load-use with a taken branch
    do_reset();
    RdE = 5; ResultSrcE = 2'b01; RegWriteE = 1; UseRs2D = 1; Rs2D = 5; PCSrcE = 1;
    cycle("t2_br");
    clear_inputs();
    cycle("t2_after");
    check("t2_flush_count_is_1", flush_count, 1);
    check("t2_stall_count_is_0", stall_count, 0);

    // 3: forwarding priority and x0 loads
    RegWriteM = 1; RegWriteW = 1; RdM = 7; RdW = 7; Rs1E = 7; Rs2E = 7;
    cycle("t3_fwd_m");
    RdM = 0;
    cycle("t3_fwd_w");
    RdE = 0; ResultSrcE = 2'b01; RegWriteE = 1; UseRs1D = 1; UseRs2D = 1;
    cycle("t3_x0_load");
    clear_inputs();

    // 4: three-cycle memory wait
    do_reset();
    MemReqM = 1;
    repeat (3) cycle("t4_wait");
    MemReadyM = 1;
    cycle("t4_ready");
    clear_inputs();
    cycle("t4_after");
    check("t4_stall_count_is_3", stall_count, 3);

    // 5: timeout after the fourth wait cycle, sticky until reset
    MemReqM = 1;
    repeat (6) cycle("t5_wait");
    MemReadyM = 1;
    cycle("t5_ready");
    clear_inputs();
    cycle("t5_after");
    check("t5_timeout_sticky", mem_timeout, 1);

    // 6: reset in the middle of a wait
    do_reset();
    MemReqM = 1;
    repeat (2) cycle("t6_wait");
    rst = 1;
    cycle("t6_rst");
    rst = 0;
    MemReqM = 0;
    cycle("t6_after");
    check("t6_counts_cleared", stall_count, 0);

    // counter saturation
    RdE = 3; ResultSrcE = 2'b01; RegWriteE = 1; UseRs1D = 1; Rs1D = 3;
    repeat (CNT_SAT + 4) cycle("sat_stall");
    clear_inputs();
    PCSrcE = 1;
    repeat (CNT_SAT + 4) cycle("sat_flush");
    clear_inputs();
    cycle("sat_end");

    // randomized traffic
    do_reset();
    wait_left = 0;
    for (int i = 0; i < 1500; i++) begin
      rst        = ($urandom_range(0, 59) == 0);
      Rs1D       = 5'($urandom_range(0, 3));
      Rs2D       = 5'($urandom_range(0, 3));
      UseRs1D    = 1'($urandom);
      UseRs2D    = 1'($urandom);
      Rs1E       = 5'($urandom_range(0, 3));
      Rs2E       = 5'($urandom_range(0, 3));
      RdE        = 5'($urandom_range(0, 3));
      RegWriteE  = 1'($urandom);
      ResultSrcE = 2'($urandom_range(0, 2));
      PCSrcE     = ($urandom_range(0, 5) == 0);
      RdM        = 5'($urandom_range(0, 3));
      RegWriteM  = 1'($urandom);
      RdW        = 5'($urandom_range(0, 3));
      RegWriteW  = 1'($urandom);
      if (wait_left == 0 && $urandom_range(0, 19) == 0)
        wait_left = $urandom_range(1, 7);
      if (wait_left > 0) begin
        MemReqM = 1; MemReadyM = 0; wait_left--;
      end else begin
        MemReqM = ($urandom_range(0, 2) == 0);
        MemReadyM = ($urandom_range(0, 3) != 0);
      end
      cycle("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
